// File: rtl/merge_bitonic_pipe_pkg.sv
// Shared definitions for the bitonic merge pipeline: size helpers and the pad key.
package merge_pkg;

    // Widest key supported by the pad constant; keys take the low WIDTH bits.
    localparam int PAD_MAX_W = 64;
    localparam logic [PAD_MAX_W-1:0] PAD = '1;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Active merge size K = 2^(mode+2), clamped to the instance maximum n.
    function automatic int active_size(input int mode, input int n);
        int k;
        if (mode >= 29) return n;
        k = 1 << (mode + 2);
        return (k > n) ? n : k;
    endfunction

endpackage

// File: rtl/merge_bitonic_pipe_if.sv
// Valid/ready bundle between a producer of half-vector pairs and the merge pipeline.
interface merge_bitonic_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N     = 16,
    parameter int MW    = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [MW-1:0]            mode;
    logic [(N/2)*WIDTH-1:0]   ina;
    logic [(N/2)*WIDTH-1:0]   inb;
    logic                     out_valid;
    logic                     out_ready;
    logic [N*WIDTH-1:0]       c;
    logic [MW-1:0]            out_mode;

    // Producer/consumer side: drives inputs and output back-pressure.
    modport master (
        output in_valid, mode, ina, inb, out_ready,
        input  in_ready, out_valid, c, out_mode
    );

    // Merge pipeline side.
    modport slave (
        input  in_valid, mode, ina, inb, out_ready,
        output in_ready, out_valid, c, out_mode
    );
endinterface

// File: rtl/merge_bitonic_pipe_cmp_swap.sv
// Compare/exchange element: orders one key pair, equal keys pass straight through.
module cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    logic swap;

    // Swap only on strict unsigned greater-than so ties keep their lanes.
    always_comb begin
        swap = (a > b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end
endmodule

// File: rtl/merge_bitonic_pipe.sv
// Pipelined bitonic merge: two sorted halves in, one ascending vector out,
// one half-cleaner level per register stage, run-time selectable merge size.
module merge_bitonic_pipe
    import merge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 16,
    parameter int MW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    merge_bitonic_pipe_if.slave   bus
);
    localparam int LOG_N = clog2(N);
    localparam int HALF  = N / 2;
    localparam logic [WIDTH-1:0] PAD_KEY = PAD[WIDTH-1:0];

    // Lanes at or above the active size carry no result and read as zero.
    function automatic logic [WIDTH-1:0] mask_key(input logic [WIDTH-1:0] key,
                                                  input int lane, input int k);
        return (lane < k) ? key : '0;
    endfunction

    logic                en;
    int                  k_in;
    int                  k_out;
    logic [WIDTH-1:0]    data_p0 [N];
    logic [WIDTH-1:0]    stg_in  [LOG_N][N];
    logic [WIDTH-1:0]    nxt_p   [LOG_N][N];
    logic [WIDTH-1:0]    data_p  [LOG_N][N];
    logic                vld_p   [LOG_N];
    logic [MW-1:0]       mode_p  [LOG_N];

    // Whole pipe advances together; it only stalls when a finished result is waiting.
    assign en            = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_p[LOG_N-1];
    assign bus.out_mode  = mode_p[LOG_N-1];

    // Pad inactive lanes and fold B in reversed so the input is bitonic for every mode.
    always_comb begin
        k_in = active_size(int'(bus.mode), N);
        for (int i = 0; i < HALF; i++) begin
            data_p0[i]       = (i < k_in / 2) ? bus.ina[i*WIDTH +: WIDTH] : PAD_KEY;
            data_p0[N-1-i]   = (i < k_in / 2) ? bus.inb[i*WIDTH +: WIDTH] : PAD_KEY;
        end
    end

    // Half-cleaner network: stage s compares lanes d = N >> (s+1) apart inside blocks of 2d.
    for (genvar s = 0; s < LOG_N; s++) begin : g_stage
        localparam int D = N >> (s + 1);

        for (genvar l = 0; l < N; l++) begin : g_lane
            if (s == 0) begin : g_first
                assign stg_in[s][l] = data_p0[l];
            end else begin : g_next
                assign stg_in[s][l] = data_p[s-1][l];
            end
        end

        for (genvar j = 0; j < HALF; j++) begin : g_cs
            localparam int LO = (j / D) * 2 * D + (j % D);
            cmp_swap #(.WIDTH(WIDTH)) u_cs (
                .a  (stg_in[s][LO]),
                .b  (stg_in[s][LO+D]),
                .lo (nxt_p[s][LO]),
                .hi (nxt_p[s][LO+D])
            );
        end
    end

    // Stage registers: data, valid and mode shift together under the shared enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LOG_N; s++) begin
                vld_p[s]  <= 1'b0;
                mode_p[s] <= '0;
                for (int l = 0; l < N; l++) data_p[s][l] <= '0;
            end
        end else if (en) begin
            vld_p[0]  <= bus.in_valid;
            mode_p[0] <= bus.mode;
            for (int s = 1; s < LOG_N; s++) begin
                vld_p[s]  <= vld_p[s-1];
                mode_p[s] <= mode_p[s-1];
            end
            for (int s = 0; s < LOG_N; s++) begin
                for (int l = 0; l < N; l++) data_p[s][l] <= nxt_p[s][l];
            end
        end
    end

    // Output: pads sorted to the top lanes are dropped by zeroing everything at or above K.
    always_comb begin
        k_out = active_size(int'(mode_p[LOG_N-1]), N);
        bus.c = '0;
        for (int l = 0; l < N; l++) begin
            bus.c[l*WIDTH +: WIDTH] = mask_key(data_p[LOG_N-1][l], l, k_out);
        end
    end

endmodule

// File: tb/tb_merge_bitonic_pipe.sv
// Directed and soak bench for merge_bitonic_pipe (WIDTH=8, N=16, MW=2).
module tb_merge_bitonic_pipe;
    localparam int WIDTH = 8;
    localparam int N     = 16;
    localparam int MW    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    merge_bitonic_pipe_if #(.WIDTH(WIDTH), .N(N), .MW(MW)) bus ();

    merge_bitonic_pipe #(.WIDTH(WIDTH), .N(N), .MW(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int acc   = 0;
    int got   = 0;

    logic [7:0]   a_arr [8];
    logic [7:0]   b_arr [8];
    logic [127:0] exp_c;
    logic [1:0]   exp_m;
    logic [129:0] sb [$];
    logic         held;
    logic [127:0] held_c;
    logic [1:0]   held_m;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, req);
        end
    endtask

    // Reference: plain insertion sort of the 2*(K/2) active keys.
    function automatic logic [127:0] model(input logic [1:0] md);
        int k;
        logic [7:0] v [16];
        logic [7:0] t;
        logic [127:0] r;
        k = 4 << md;
        if (k > 16) k = 16;
        for (int i = 0; i < 16; i++) v[i] = 8'h00;
        for (int i = 0; i < k / 2; i++) begin
            v[i]       = a_arr[i];
            v[k/2 + i] = b_arr[i];
        end
        for (int i = 1; i < k; i++) begin
            for (int j = i; j > 0; j--) begin
                if (v[j-1] > v[j]) begin
                    t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < k; i++) r[i*8 +: 8] = v[i];
        return r;
    endfunction

    function automatic logic [7:0] rnd_key();
        if ($urandom_range(0, 7) == 0) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic rand_halves();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            a_arr[i] = rnd_key();
            b_arr[i] = rnd_key();
        end
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0; j--) begin
                if (a_arr[j-1] > a_arr[j]) begin t = a_arr[j]; a_arr[j] = a_arr[j-1]; a_arr[j-1] = t; end
                if (b_arr[j-1] > b_arr[j]) begin t = b_arr[j]; b_arr[j] = b_arr[j-1]; b_arr[j-1] = t; end
            end
        end
    endtask

    task automatic set_lane(input int lane, input int val);
        exp_c[lane*8 +: 8] = 8'(val);
    endtask

    // One clock: drive, check handshake/stability, track transfers, advance past the edge.
    task automatic run_cycle(input logic vld, input logic [1:0] md, input logic ordy);
        logic [129:0] e;
        bus.in_valid  = vld;
        bus.mode      = md;
        bus.out_ready = ordy;
        for (int i = 0; i < 8; i++) begin
            bus.ina[i*8 +: 8] = a_arr[i];
            bus.inb[i*8 +: 8] = b_arr[i];
        end
        #1;
        if (held) begin
            chk("hold_c", bus.c, held_c);
            chk("hold_mode", {126'b0, bus.out_mode}, {126'b0, held_m});
        end
        if (bus.out_valid && !bus.out_ready) begin
            chk("in_ready_bp", {127'b0, bus.in_ready}, 128'd0);
            held   = 1'b1;
            held_c = bus.c;
            held_m = bus.out_mode;
        end else begin
            held = 1'b0;
        end
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back({exp_m, exp_c});
            acc++;
        end
        if (bus.out_valid && bus.out_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_underflow: got result %h with no vector in flight, want none", bus.c);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_c", bus.c, e[127:0]);
                chk("out_mode", {126'b0, bus.out_mode}, {126'b0, e[129:128]});
                got++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int g0;
        int a0;
        int cyc;
        logic [1:0] md;

        rst = 1'b1;
        held = 1'b0;
        bus.in_valid = 1'b0;
        bus.mode = '0;
        bus.ina = '0;
        bus.inb = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin a_arr[i] = 8'h00; b_arr[i] = 8'h00; end
        exp_c = '0;
        exp_m = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        chk("rst_c", bus.c, 128'd0);
        chk("rst_out_mode", {126'b0, bus.out_mode}, 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {127'b0, bus.in_ready}, 128'd1);

        // Full merge, mode 2: odds and evens interleave to 0..15
        for (int i = 0; i < 8; i++) begin a_arr[i] = 8'(2*i + 1); b_arr[i] = 8'(2*i); end
        exp_c = '0;
        for (int i = 0; i < 16; i++) set_lane(i, i);
        exp_m = 2'd2;
        run_cycle(1'b1, 2'd2, 1'b1);
        run_cycle(1'b0, 2'd2, 1'b1);
        run_cycle(1'b0, 2'd2, 1'b1);
        chk("lat3_out_valid", {127'b0, bus.out_valid}, 128'd0);
        run_cycle(1'b0, 2'd2, 1'b1);
        chk("lat4_out_valid", {127'b0, bus.out_valid}, 128'd1);
        chk("full_c", bus.c, exp_c);
        chk("full_mode", {126'b0, bus.out_mode}, 128'd2);
        run_cycle(1'b0, 2'd2, 1'b1);

        // Mode 3 clamps to K=16: same result, mode 3 carried through
        exp_m = 2'd3;
        run_cycle(1'b1, 2'd3, 1'b1);
        repeat (4) run_cycle(1'b0, 2'd0, 1'b1);

        // QPSK size, mode 0: only two keys per half count
        rand_halves();
        a_arr[0] = 8'd9;  a_arr[1] = 8'd20;
        b_arr[0] = 8'd3;  b_arr[1] = 8'd40;
        exp_c = '0;
        set_lane(0, 3); set_lane(1, 9); set_lane(2, 20); set_lane(3, 40);
        exp_m = 2'd0;
        run_cycle(1'b1, 2'd0, 1'b1);
        repeat (4) run_cycle(1'b0, 2'd0, 1'b1);

        // Duplicates and all-ones keys, mode 1
        rand_halves();
        a_arr[0] = 8'd0; a_arr[1] = 8'd0;   a_arr[2] = 8'd255; a_arr[3] = 8'd255;
        b_arr[0] = 8'd0; b_arr[1] = 8'd128; b_arr[2] = 8'd255; b_arr[3] = 8'd255;
        exp_c = '0;
        set_lane(0, 0); set_lane(1, 0); set_lane(2, 0); set_lane(3, 128);
        set_lane(4, 255); set_lane(5, 255); set_lane(6, 255); set_lane(7, 255);
        exp_m = 2'd1;
        run_cycle(1'b1, 2'd1, 1'b1);
        repeat (4) run_cycle(1'b0, 2'd0, 1'b1);
        chk("directed_delivered", 128'(got), 128'd4);

        // Back-pressure: six back-to-back, five stalled cycles, then drain
        g0 = got;
        for (int v = 0; v < 6; v++) begin
            rand_halves();
            md = 2'($urandom_range(0, 3));
            exp_c = model(md);
            exp_m = md;
            run_cycle(1'b1, md, 1'b1);
        end
        repeat (5) run_cycle(1'b0, 2'd0, 1'b0);
        repeat (10) run_cycle(1'b0, 2'd0, 1'b1);
        chk("bp_delivered", 128'(got - g0), 128'd6);
        chk("bp_sb_empty", 128'(sb.size()), 128'd0);

        // Reset mid-flight: three vectors in flight, one already presented
        for (int v = 0; v < 3; v++) begin
            rand_halves();
            exp_c = model(2'd2);
            exp_m = 2'd2;
            run_cycle(1'b1, 2'd2, 1'b1);
        end
        run_cycle(1'b0, 2'd0, 1'b0);
        chk("pre_rst_out_valid", {127'b0, bus.out_valid}, 128'd1);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        held = 1'b0;
        chk("flush_out_valid", {127'b0, bus.out_valid}, 128'd0);
        chk("flush_c", bus.c, 128'd0);
        chk("flush_out_mode", {126'b0, bus.out_mode}, 128'd0);
        g0 = got;
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b0, 2'd0, 1'b1);
            chk("flush_quiet", {127'b0, bus.out_valid}, 128'd0);
        end
        rand_halves();
        exp_c = model(2'd1);
        exp_m = 2'd1;
        run_cycle(1'b1, 2'd1, 1'b1);
        run_cycle(1'b0, 2'd0, 1'b1);
        run_cycle(1'b0, 2'd0, 1'b1);
        chk("post_rst_lat3", {127'b0, bus.out_valid}, 128'd0);
        run_cycle(1'b0, 2'd0, 1'b1);
        chk("post_rst_lat4", {127'b0, bus.out_valid}, 128'd1);
        run_cycle(1'b0, 2'd0, 1'b1);
        chk("post_rst_delivered", 128'(got - g0), 128'd1);

        // Random soak with random mode, in_valid and out_ready
        a0 = acc;
        g0 = got;
        cyc = 0;
        while ((acc - a0) < 10000 && cyc < 40000) begin
            md = 2'($urandom_range(0, 3));
            rand_halves();
            exp_c = model(md);
            exp_m = md;
            run_cycle($urandom_range(0, 4) != 0, md, $urandom_range(0, 3) != 0);
            cyc++;
        end
        repeat (12) run_cycle(1'b0, 2'd0, 1'b1);
        chk("soak_accepted", 128'(acc - a0), 128'd10000);
        chk("soak_delivered", 128'(got - g0), 128'd10000);
        chk("soak_sb_empty", 128'(sb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
